// File: rtl/vga_pixel_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_sink_pkg
// Purpose  : Shared display constants, sink state encoding and address helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pixel_sink_pkg;

    localparam logic [7:0]  FB_WIDTH     = 8'd160;
    localparam logic [6:0]  FB_HEIGHT    = 7'd120;
    localparam logic [14:0] FB_SIZE      = 15'd19200;
    localparam logic [14:0] FB_LAST_ADDR = FB_SIZE - 15'd1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // y*160 + x as (y*128) + (y*32) + x, keeping the datapath multiplier-free
    function automatic logic [14:0] fb_addr_of(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_sink_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo
// Purpose  : Synchronous FIFO with full/empty flags; push on full is allowed
//            when a pop happens on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_sink
// Purpose  : Queues pixel writes into the framebuffer and performs full-frame
//            clears on request, preserving the order of surrounding pixels.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_sink
    import vga_pixel_sink_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_write,
    input  logic        clear_start,
    input  logic [2:0]  clear_colour,
    output logic        clear_done,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_we,
    output logic [7:0]  dropped
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    r_state;
    logic [14:0]   r_clear_addr;
    logic [2:0]    r_clear_colour;
    logic [CW-1:0] r_drain_left;
    logic          r_fb_we;
    logic [14:0]   r_fb_addr;
    logic [2:0]    r_fb_data;
    logic          r_clear_done;
    logic [7:0]    r_dropped;

    logic          w_in_range;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic [17:0]   w_head;

    assign w_in_range = (vga_x < FB_WIDTH) && (vga_y < FB_HEIGHT);

    // Pops use the registered empty flag, so a pixel pushed into an empty
    // queue is never forwarded on the same edge.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_DRAIN) && (r_drain_left != '0)));
    assign w_push       = vga_write && w_in_range && (!w_full || w_pop);
    assign w_drop       = vga_write && !w_push;
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (18)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .din    ({fb_addr_of(vga_x, vga_y), vga_colour}),
        .dout   (w_head),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_clear_addr   <= '0;
            r_clear_colour <= '0;
            r_drain_left   <= '0;
            r_fb_we        <= 1'b0;
            r_fb_addr      <= '0;
            r_fb_data      <= '0;
            r_clear_done   <= 1'b0;
            r_dropped      <= '0;
        end else begin
            r_fb_we      <= 1'b0;
            r_clear_done <= 1'b0;

            if (w_pop) begin
                r_fb_we   <= 1'b1;
                r_fb_addr <= w_head[17:3];
                r_fb_data <= w_head[2:0];
            end

            if (w_drop && (r_dropped != 8'hFF)) begin
                r_dropped <= r_dropped + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    // Entries present after this edge predate the clear request
                    if (clear_start) begin
                        r_clear_colour <= clear_colour;
                        r_drain_left   <= w_count_next;
                        r_state        <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_left == '0) begin
                        r_clear_addr <= '0;
                        r_state      <= ST_CLEAR;
                    end else if (w_pop) begin
                        r_drain_left <= r_drain_left - CW'(1);
                    end
                end
                ST_CLEAR: begin
                    r_fb_we   <= 1'b1;
                    r_fb_addr <= r_clear_addr;
                    r_fb_data <= r_clear_colour;
                    if (r_clear_addr == FB_LAST_ADDR) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_clear_addr <= r_clear_addr + 15'd1;
                    end
                end
                ST_DONE: begin
                    r_clear_done <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign clear_done = r_clear_done;
    assign dropped    = r_dropped;

endmodule
`default_nettype wire
